wb_trace_unit: RTL

Downstream consumer of the MIPS core's write-back port (result value plus destination register address). Captures every qualified register write into a small FIFO, then serializes each record as a 5-byte frame over a byte valid/ready stream toward the debug UART transmitter. It lets the host trace program execution without stalling the pipeline. Overflowed events are dropped and flagged, never back-pressured.

---
 rtl/wb_trace_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_trace_unit.sv
// Write-back trace unit: buffers qualified register writes and streams each one as a 5-byte frame.
// Build option: define TRACE_DROP_R0_EN to discard writes to register 0 before they reach the FIFO.
module wb_trace_unit #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_wb_valid,
    input  logic [4:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_fifo_full,
    output logic             o_fifo_empty,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {IDLE, ADDR, B3, B2, B1, B0} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [36:0]       mem [FIFO_DEPTH];
    logic [4:0]        frame_addr_reg;
    logic [31:0]       frame_data_reg;
    logic [7:0]        frame_bytes [4];
    logic              overflow_reg;
    logic [CNT_W-1:0]  drop_count_reg;

    logic event_ok, fifo_full, fifo_empty, pop, push, drop;

`ifdef TRACE_DROP_R0_EN
    assign event_ok = i_enable & i_wb_valid & (i_wb_addr != 5'd0);
`else
    assign event_ok = i_enable & i_wb_valid;
`endif

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign push = event_ok && (!fifo_full || pop);
    assign drop = event_ok && fifo_full && !pop;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bytes
            assign frame_bytes[gi] = frame_data_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {3'b000, frame_addr_reg};
                if (i_tx_ready) state_next = B3;
            end
            B3: begin
                o_tx_valid = 1'b1;
                o_tx_data  = frame_bytes[3];
                if (i_tx_ready) state_next = B2;
            end
            B2: begin
                o_tx_valid = 1'b1;
                o_tx_data  = frame_bytes[2];
                if (i_tx_ready) state_next = B1;
            end
            B1: begin
                o_tx_valid = 1'b1;
                o_tx_data  = frame_bytes[1];
                if (i_tx_ready) state_next = B0;
            end
            B0: begin
                o_tx_valid = 1'b1;
                o_tx_data  = frame_bytes[0];
                // Chain straight into the next frame so back-to-back records have no bubble.
                if (i_tx_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ADDR;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_count_reg != CNT_MAX) drop_count_reg <= drop_count_reg + CNT_ONE;
            end
        end
    end

    // Storage and frame register carry no reset: the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= {i_wb_addr, i_wb_data};
    end

    always_ff @(posedge clk) begin
        if (pop) {frame_addr_reg, frame_data_reg} <= mem[rd_ptr_reg[AW-1:0]];
    end

    assign o_fifo_full  = fifo_full;
    assign o_fifo_empty = fifo_empty;
    assign o_overflow   = overflow_reg;
    assign o_drop_count = drop_count_reg;
endmodule
